if_fetch_bpred: RTL

//  Instruction-fetch stage of the 5-stage pipeline; feeds the IF/ID register directly.

---
 rtl/if_fetch_bpred_if.sv | 27 ++
 rtl/if_fetch_bpred.sv | 102 ++++++++++
 2 files changed

// File: rtl/if_fetch_bpred_if.sv
// Fetch-stage bus: pipeline control and EX branch resolution in; PC and prediction out.
// The slave modport is the fetch stage. The master modport is the surrounding pipeline.
interface if_fetch_bpred_if;
  logic        PC_Write;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Addr;
  logic        Upd_Valid;
  logic [31:0] Upd_PC;
  logic        Upd_Taken;
  logic [31:0] Upd_Target;
  logic [31:0] Fetch_PC;
  logic        Choice;
  logic [31:0] Chosen_Addr;
  logic        IF_ID_Flush;

  modport master (
    output PC_Write, Redirect_Valid, Redirect_Addr,
    output Upd_Valid, Upd_PC, Upd_Taken, Upd_Target,
    input  Fetch_PC, Choice, Chosen_Addr, IF_ID_Flush
  );

  modport slave (
    input  PC_Write, Redirect_Valid, Redirect_Addr,
    input  Upd_Valid, Upd_PC, Upd_Taken, Upd_Target,
    output Fetch_PC, Choice, Chosen_Addr, IF_ID_Flush
  );
endinterface

// File: rtl/if_fetch_bpred.sv
// Instruction fetch with a direct-mapped BTB and 2-bit counters.
// The BTB is built only when BPRED_EN is defined; otherwise the next PC is always PC+4.
module if_fetch_bpred #(
  parameter int          BTB_ENTRIES = 64,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  if_fetch_bpred_if.slave bus
);

  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic [31:0] pc_r;
  logic [31:0] pc_plus4_s;
  logic [31:0] chosen_s;
  logic        choice_s;

  assign pc_plus4_s = pc_r + 32'd4;

`ifdef BPRED_EN
  logic                valid_r  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] tag_r    [BTB_ENTRIES];
  logic [31:0]         target_r [BTB_ENTRIES];
  logic [1:0]          ctr_r    [BTB_ENTRIES];

  logic [IDX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0] tag_s;
  logic                hit_s;
  logic [IDX_BITS-1:0] upd_idx_s;
  logic [TAG_BITS-1:0] upd_tag_s;
  logic                upd_hit_s;

  assign idx_s     = pc_r[IDX_BITS+1:2];
  assign tag_s     = pc_r[31:IDX_BITS+2];
  assign hit_s     = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign upd_idx_s = bus.Upd_PC[IDX_BITS+1:2];
  assign upd_tag_s = bus.Upd_PC[31:IDX_BITS+2];
  assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

  // Lookup uses pre-update table contents
  always_comb begin
    choice_s = hit_s && ctr_r[idx_s][1];
    chosen_s = pc_plus4_s;
    if (choice_s) begin
      chosen_s = target_r[idx_s];
    end else begin
      chosen_s = pc_plus4_s;
    end
  end

  // BTB training from EX; reset drops any update presented in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        ctr_r[i]   <= 2'd0;
      end
    end else if (bus.Upd_Valid) begin
      if (upd_hit_s) begin
        if (bus.Upd_Taken) begin
          if (ctr_r[upd_idx_s] != 2'd3) ctr_r[upd_idx_s] <= ctr_r[upd_idx_s] + 2'd1;
          target_r[upd_idx_s] <= bus.Upd_Target;
        end else begin
          if (ctr_r[upd_idx_s] != 2'd0) ctr_r[upd_idx_s] <= ctr_r[upd_idx_s] - 2'd1;
        end
      end else if (bus.Upd_Taken) begin
        valid_r[upd_idx_s]  <= 1'b1;
        tag_r[upd_idx_s]    <= upd_tag_s;
        target_r[upd_idx_s] <= bus.Upd_Target;
        ctr_r[upd_idx_s]    <= 2'd2;
      end
    end
  end
`else
  // Predictor absent: always fall through
  always_comb begin
    choice_s = 1'b0;
    chosen_s = pc_plus4_s;
  end
`endif

  // PC register: reset > redirect > stall > predicted next
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (bus.Redirect_Valid) begin
      pc_r <= bus.Redirect_Addr;
    end else if (bus.PC_Write) begin
      pc_r <= chosen_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign bus.Fetch_PC    = pc_r;
  assign bus.Choice      = choice_s;
  assign bus.Chosen_Addr = chosen_s;
  assign bus.IF_ID_Flush = bus.Redirect_Valid;

endmodule
